pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer_if.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and the SB_PLL40_CORE clock wrapper.
// The sequencer takes the slave view; the wrapper (or a bench) takes the master view.
interface pll_reset_sequencer_if #(
  parameter int RETRY_W = 2
);
  logic               PLL_LOCK;
  logic               RESTART;
  logic               PLL_RESETB;
  logic               PLL_BYPASS;
  logic               SYS_RESETN;
  logic               CLK_READY;
  logic               FAULT;
  logic               LOCK_LOST;
  logic [RETRY_W-1:0] RETRY_COUNT;

  modport slave (
    input  PLL_LOCK, RESTART,
    output PLL_RESETB, PLL_BYPASS, SYS_RESETN, CLK_READY, FAULT, LOCK_LOST, RETRY_COUNT
  );

  modport master (
    output PLL_LOCK, RESTART,
    input  PLL_RESETB, PLL_BYPASS, SYS_RESETN, CLK_READY, FAULT, LOCK_LOST, RETRY_COUNT
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for the iCE40 PLL: holds the PLL in reset, qualifies LOCK,
// releases the core reset, retries on timeout and falls back to bypass after repeated failures.
module pll_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 32,
  parameter int LOCK_TIMEOUT_CYCLES = 21000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16,
  parameter int RETRY_W             = 2
) (
  input  logic                  REFERENCECLK,
  input  logic                  RESET,
  pll_reset_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_HOLD      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               lost_reg, lost_next;
  logic               lock_meta_reg, lock_s_reg;
  logic               pll_resetb_reg, pll_bypass_reg, sys_resetn_reg;
  logic               clk_ready_reg, fault_reg;

  // Saturating increment so a long dwell can never wrap back into a match.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;
    if (bus.RESTART) begin
      state_next = ST_HOLD;
      cnt_next   = '0;
      retry_next = '0;
      lost_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still counts as success.
          if (lock_s_reg) begin
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retry_reg < RETRY_MAX) begin
              retry_next = retry_reg + RETRY_W'(1);
              state_next = ST_HOLD;
            end else begin
              state_next = ST_FAULT;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_STABLE: begin
          if (!lock_s_reg) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_RUN: begin
          cnt_next = '0;
          if (!lock_s_reg) begin
            state_next = ST_HOLD;
            lost_next  = 1'b1;
            retry_next = '0;
          end
        end
        ST_FAULT: begin
          cnt_next = '0;
        end
        default: begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= ST_HOLD;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      lost_reg       <= 1'b0;
      lock_meta_reg  <= 1'b0;
      lock_s_reg     <= 1'b0;
      pll_resetb_reg <= 1'b0;
      pll_bypass_reg <= 1'b0;
      sys_resetn_reg <= 1'b0;
      clk_ready_reg  <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      lost_reg       <= lost_next;
      lock_meta_reg  <= bus.PLL_LOCK;
      lock_s_reg     <= lock_meta_reg;
      pll_resetb_reg <= (state_next != ST_HOLD);
      pll_bypass_reg <= (state_next == ST_FAULT);
      sys_resetn_reg <= (state_next == ST_RUN) || (state_next == ST_FAULT);
      clk_ready_reg  <= (state_next == ST_RUN);
      fault_reg      <= (state_next == ST_FAULT);
    end
  end

  assign bus.PLL_RESETB  = pll_resetb_reg;
  assign bus.PLL_BYPASS  = pll_bypass_reg;
  assign bus.SYS_RESETN  = sys_resetn_reg;
  assign bus.CLK_READY   = clk_ready_reg;
  assign bus.FAULT       = fault_reg;
  assign bus.LOCK_LOST   = lost_reg;
  assign bus.RETRY_COUNT = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing (hold 4, timeout 20, stable 8, 2 retries).
// Output vector layout: {PLL_RESETB, PLL_BYPASS, SYS_RESETN, CLK_READY, FAULT, LOCK_LOST, RETRY_COUNT[1:0]}.
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  pll_reset_sequencer_if #(.RETRY_W(2)) bus ();

  pll_reset_sequencer #(
    .RESET_HOLD_CYCLES  (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16),
    .RETRY_W            (2)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.PLL_RESETB, bus.PLL_BYPASS, bus.SYS_RESETN, bus.CLK_READY,
            bus.FAULT, bus.LOCK_LOST, bus.RETRY_COUNT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %-24s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("pass %-24s value %0h", tag, got);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Cycles until PLL_RESETB leaves 0 (bounded).
  task automatic measure_low(output int cnt);
    cnt = 0;
    while (bus.PLL_RESETB === 1'b0 && cnt < 100) begin
      tick(1);
      cnt++;
    end
  endtask

  // Cycles until PLL_RESETB drops or FAULT rises (bounded).
  task automatic measure_high(output int cnt);
    cnt = 0;
    while (bus.PLL_RESETB === 1'b1 && bus.FAULT === 1'b0 && cnt < 100) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.PLL_LOCK = 1'b0;
    bus.RESTART  = 1'b0;
    #2;
    chk("reset_state", outs(), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: nominal start
    measure_low(n);
    chk("hold_len_first", n, 4);
    tick(5);
    bus.PLL_LOCK = 1'b1;
    // Lock sampled on the next edge; 2 sync edges + WAIT->STABLE edge + 8 stable edges.
    tick(10);
    chk("before_release", outs(), 8'h80);
    tick(1);
    chk("run_reached", outs(), 8'hB0);

    // 4: lock loss in RUN
    bus.PLL_LOCK = 1'b0;
    tick(2);
    chk("run_during_sync", outs(), 8'hB0);
    tick(1);
    chk("lock_loss_hold", outs(), 8'h04);
    measure_low(n);
    chk("hold_len_after_loss", n, 4);
    bus.PLL_LOCK = 1'b1;

    // 2: one-cycle glitch lands on stable count 5
    tick(6);
    bus.PLL_LOCK = 1'b0;
    tick(1);
    bus.PLL_LOCK = 1'b1;
    tick(2);
    chk("glitch_back_wait", outs(), 8'h84);
    tick(8);
    chk("glitch_no_early_run", outs(), 8'h84);
    tick(1);
    chk("relock_run_lost_sticky", outs(), 8'hB4);

    // 3: no lock ever, entered through RESTART from RUN
    bus.PLL_LOCK = 1'b0;
    bus.RESTART  = 1'b1;
    tick(1);
    bus.RESTART  = 1'b0;
    chk("restart_from_run", outs(), 8'h00);
    for (int a = 0; a < 3; a++) begin
      chk($sformatf("retry_in_hold_%0d", a), bus.RETRY_COUNT, a);
      measure_low(n);
      chk($sformatf("hold_len_try_%0d", a), n, 4);
      measure_high(n);
      chk($sformatf("wait_len_try_%0d", a), n, 20);
    end
    chk("fault_outputs", outs(), 8'hEA);
    bus.PLL_LOCK = 1'b1;
    tick(12);
    chk("fault_ignores_lock", outs(), 8'hEA);

    // 5: RESTART from FAULT with lock already high
    bus.RESTART = 1'b1;
    tick(1);
    bus.RESTART = 1'b0;
    chk("restart_from_fault", outs(), 8'h00);
    measure_low(n);
    chk("hold_len_after_fault", n, 4);
    tick(8);
    chk("stable_after_fault", outs(), 8'h80);
    tick(1);
    chk("run_after_fault", outs(), 8'hB0);

    // 6: async reset in the middle of WAIT_LOCK
    bus.PLL_LOCK = 1'b0;
    bus.RESTART  = 1'b1;
    tick(1);
    bus.RESTART  = 1'b0;
    measure_low(n);
    chk("hold_len_pre_reset", n, 4);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 8'h00);
    #2;
    rst_n = 1'b1;
    measure_low(n);
    chk("hold_len_post_reset", n, 4);

    // RESTART during HOLD restarts the hold count
    bus.RESTART = 1'b1;
    tick(1);
    bus.RESTART = 1'b0;
    tick(2);
    bus.RESTART = 1'b1;
    tick(1);
    bus.RESTART = 1'b0;
    measure_low(n);
    chk("hold_len_rerestart", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
